frame_writer: RTL and testbench



---
 rtl/frame_writer_pkg.sv | 24 ++
 rtl/rect_addr_gen.sv | 70 +++++++
 rtl/frame_writer.sv | 135 +++++++++++++
 tb/tb_frame_writer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_writer_pkg.sv
// Shared constants and types for the rectangle framebuffer writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: framebuffer geometry constants, FSM state enum, RGB pixel struct.
package frame_writer_pkg;

  localparam int IMG_W  = 256;
  localparam int IMG_H  = 256;
  localparam int ADDR_W = 16;
  localparam int PIX_W  = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } fw_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

endpackage

// File: rtl/rect_addr_gen.sv
// Raster address generator for one rectangle: walks columns, then rows.
// Latency: addr/last are combinational from the current position; load/step act at the clock edge.
// Backpressure: advances only when step is high, so the caller gates it with the pixel handshake.
// Ports: clk, rst (sync, active-high); load + x/y/w/h start a rectangle; step advances one pixel;
//        addr is the current pixel address, last_col flags the row end, last flags the final pixel.
module rect_addr_gen #(
  parameter int IMG_W  = 256,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [7:0]        x,
  input  logic [7:0]        y,
  input  logic [8:0]        w,
  input  logic [8:0]        h,
  output logic [ADDR_W-1:0] addr,
  output logic              last_col,
  output logic              last
);

  localparam int X_W = $clog2(IMG_W);

  logic [7:0]        x0;
  logic [8:0]        w_q;
  logic [8:0]        h_q;
  logic [7:0]        cur_x;
  logic [8:0]        col;
  logic [8:0]        row;
  logic [ADDR_W-1:0] row_base;

  // Width is a power of two, so the row base is just y shifted up.
  always_ff @(posedge clk) begin
    if (rst) begin
      x0       <= '0;
      w_q      <= '0;
      h_q      <= '0;
      cur_x    <= '0;
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (load) begin
      x0       <= x;
      w_q      <= w;
      h_q      <= h;
      cur_x    <= x;
      col      <= '0;
      row      <= '0;
      row_base <= ADDR_W'(y) << X_W;
    end else if (step) begin
      if (last_col) begin
        // Stepping past the final pixel moves to a row that is never used.
        cur_x    <= x0;
        col      <= '0;
        row      <= row + 9'd1;
        row_base <= row_base + ADDR_W'(IMG_W);
      end else begin
        cur_x <= cur_x + 8'd1;
        col   <= col + 9'd1;
      end
    end
  end

  // w_q/h_q are at least 1 for any accepted command, so the -1 never underflows in use.
  assign last_col = (col == w_q - 9'd1);
  assign last     = last_col && (row == h_q - 9'd1);
  assign addr     = row_base + ADDR_W'(cur_x);

endmodule

// File: rtl/frame_writer.sv
// Rectangle pixel writer: accepts a rectangle command, then writes streamed pixels in raster order.
// Latency: command accepted at edge N -> pix_ready at N+1; pixel at edge N -> write strobe during N+1.
// Backpressure: cmd_ready only in IDLE, pix_ready only in WRITE; pix_valid low simply stalls the raster.
// Ports: clk, rst (sync, active-high); cmd_* rectangle command; pix_* pixel stream; abort cancels;
//        wr_en/wr_addr/wr_data framebuffer write port; busy, done (pulse), err (pulse, rejected command).
module frame_writer #(
  parameter int IMG_W  = frame_writer_pkg::IMG_W,
  parameter int IMG_H  = frame_writer_pkg::IMG_H,
  parameter int ADDR_W = frame_writer_pkg::ADDR_W,
  parameter int PIX_W  = frame_writer_pkg::PIX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [8:0]        cmd_w,
  input  logic [8:0]        cmd_h,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              abort,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import frame_writer_pkg::*;

  fw_state_t         state;
  fw_state_t         state_nxt;
  logic              load;
  logic              step;
  logic              legal;
  logic              gen_last;
  logic              gen_last_col;
  logic [ADDR_W-1:0] gen_addr;
  logic [9:0]        sum_x;
  logic [9:0]        sum_y;

  // 10-bit sums so x+w cannot wrap even for out-of-range widths up to 511.
  assign sum_x = {2'b00, cmd_x} + {1'b0, cmd_w};
  assign sum_y = {2'b00, cmd_y} + {1'b0, cmd_h};
  assign legal = (cmd_w != 9'd0) && (cmd_h != 9'd0) &&
                 (sum_x <= 10'(IMG_W)) && (sum_y <= 10'(IMG_H));

  rect_addr_gen #(
    .IMG_W  (IMG_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .x        (cmd_x),
    .y        (cmd_y),
    .w        (cmd_w),
    .h        (cmd_h),
    .addr     (gen_addr),
    .last_col (gen_last_col),
    .last     (gen_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    pix_ready = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && legal) begin
          load      = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        pix_ready = 1'b1;
        step      = pix_valid;
        // Abort wins over completion: a final pixel arriving with abort is written, but no done.
        if (abort) begin
          state_nxt = IDLE;
        end else if (pix_valid && gen_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Hold off both handshakes while reset is asserted so nothing is accepted or written.
    if (rst) begin
      cmd_ready = 1'b0;
      pix_ready = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      err     <= 1'b0;
    end else begin
      wr_en <= step;
      if (step) begin
        wr_addr <= gen_addr;
        wr_data <= pix_data;
      end
      err <= cmd_ready && cmd_valid && !legal;
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// Directed self-checking bench for frame_writer: inputs driven and outputs checked on the falling edge.
module tb_frame_writer;

  import frame_writer_pkg::*;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_x;
  logic [7:0]        cmd_y;
  logic [8:0]        cmd_w;
  logic [8:0]        cmd_h;
  logic              pix_valid;
  logic              pix_ready;
  logic [PIX_W-1:0]  pix_data;
  logic              abort;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              busy;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  frame_writer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .abort     (abort),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Presents a command for exactly one rising edge.
  task automatic send_cmd(input int x, input int y, input int w, input int h);
    cmd_valid = 1'b1;
    cmd_x     = 8'(x);
    cmd_y     = 8'(y);
    cmd_w     = 9'(w);
    cmd_h     = 9'(h);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    pixel_t px;
    int     exp_addr [6];
    int     nwr;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    pix_valid = 1'b0;
    pix_data  = '0;
    abort     = 1'b0;

    // ---- reset values ----
    tick();
    tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_wr_en",     wr_en,     0);
    chk("rst_wr_addr",   wr_addr,   0);
    chk("rst_wr_data",   wr_data,   0);
    chk("rst_busy",      busy,      0);
    chk("rst_done",      done,      0);
    chk("rst_err",       err,       0);
    rst = 1'b0;
    tick();
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // ---- 1x1 at origin ----
    send_cmd(0, 0, 1, 1);
    chk("t1_busy",      busy,      1);
    chk("t1_pix_ready", pix_ready, 1);
    chk("t1_cmd_ready", cmd_ready, 0);
    px = '{r: 8'hFF, g: 8'h00, b: 8'h00};
    pix_valid = 1'b1;
    pix_data  = px;
    tick();
    pix_valid = 1'b0;
    chk("t1_wr_en",   wr_en,   1);
    chk("t1_wr_addr", wr_addr, 0);
    chk("t1_wr_data", wr_data, 32'hFF0000);
    chk("t1_done",    done,    1);
    chk("t1_cmd_ready_during_done", cmd_ready, 0);
    tick();
    chk("t1_cmd_ready_after", cmd_ready, 1);
    chk("t1_wr_en_after",     wr_en,     0);
    chk("t1_done_after",      done,      0);
    chk("t1_busy_after",      busy,      0);

    // ---- 2x3 at the right edge, continuous stream ----
    exp_addr = '{2814, 2815, 3070, 3071, 3326, 3327};
    send_cmd(254, 10, 2, 3);
    for (int i = 0; i < 6; i++) begin
      pix_valid = 1'b1;
      pix_data  = 24'(32'h00A000 + i);
      tick();
      chk("t2_wr_en",   wr_en,   1);
      chk("t2_wr_addr", wr_addr, exp_addr[i]);
      chk("t2_wr_data", wr_data, 32'h00A000 + i);
      chk("t2_done",    done,    (i == 5) ? 1 : 0);
    end
    pix_valid = 1'b0;
    tick();
    chk("t2_done_after",  done,      0);
    chk("t2_wr_en_after", wr_en,     0);
    chk("t2_cmd_ready",   cmd_ready, 1);

    // ---- rejected commands ----
    send_cmd(200, 0, 100, 1);
    chk("t3_err",       err,       1);
    chk("t3_busy",      busy,      0);
    chk("t3_wr_en",     wr_en,     0);
    chk("t3_cmd_ready", cmd_ready, 1);
    tick();
    chk("t3_err_clear", err,  0);
    chk("t3_busy_idle", busy, 0);
    send_cmd(3, 3, 0, 2);
    chk("t3_w0_err",  err,  1);
    chk("t3_w0_busy", busy, 0);
    send_cmd(0, 200, 4, 57);
    chk("t3_ybound_err", err, 1);
    tick();
    chk("t3_err_clear2", err, 0);

    // ---- full-width bottom row, pix_valid every other cycle ----
    send_cmd(0, 255, 256, 1);
    chk("t4_busy", busy, 1);
    nwr = 0;
    for (int c = 0; c < 512; c++) begin
      pix_valid = (c % 2 == 0);
      pix_data  = 24'(c);
      tick();
      chk("t4_wr_en", wr_en, (c % 2 == 0) ? 1 : 0);
      if (c % 2 == 0) begin
        chk("t4_wr_addr", wr_addr, 65280 + c / 2);
        chk("t4_wr_data", wr_data, c);
        nwr++;
      end
      chk("t4_done", done, (c == 510) ? 1 : 0);
    end
    pix_valid = 1'b0;
    chk("t4_write_count", nwr, 256);
    chk("t4_cmd_ready", cmd_ready, 1);

    // ---- abort after 3 of 4 pixels ----
    send_cmd(5, 5, 2, 2);
    pix_valid = 1'b1;
    pix_data  = 24'h111111;
    tick();
    chk("t5_wr_addr0", wr_addr, 1285);
    pix_data = 24'h222222;
    tick();
    chk("t5_wr_addr1", wr_addr, 1286);
    pix_data = 24'h333333;
    abort    = 1'b1;
    tick();
    abort     = 1'b0;
    pix_valid = 1'b0;
    chk("t5_wr_en2",     wr_en,     1);
    chk("t5_wr_addr2",   wr_addr,   1541);
    chk("t5_wr_data2",   wr_data,   32'h333333);
    chk("t5_done",       done,      0);
    chk("t5_busy",       busy,      0);
    chk("t5_cmd_ready",  cmd_ready, 1);
    chk("t5_pix_ready",  pix_ready, 0);
    tick();
    chk("t5_wr_en_after", wr_en, 0);
    chk("t5_done_after",  done,  0);

    // ---- reset in the middle of a rectangle ----
    send_cmd(0, 0, 4, 4);
    pix_valid = 1'b1;
    pix_data  = 24'h0000AA;
    tick();
    tick();
    chk("t6_pre_wr_addr", wr_addr, 1);
    rst = 1'b1;
    tick();
    chk("t6_wr_en",     wr_en,     0);
    chk("t6_wr_addr",   wr_addr,   0);
    chk("t6_wr_data",   wr_data,   0);
    chk("t6_busy",      busy,      0);
    chk("t6_pix_ready", pix_ready, 0);
    chk("t6_done",      done,      0);
    chk("t6_err",       err,       0);
    chk("t6_cmd_ready", cmd_ready, 0);
    rst       = 1'b0;
    pix_valid = 1'b0;
    tick();
    chk("t6_cmd_ready_after", cmd_ready, 1);
    chk("t6_wr_en_after",     wr_en,     0);
    send_cmd(1, 2, 1, 2);
    pix_valid = 1'b1;
    pix_data  = 24'h010203;
    tick();
    chk("t6b_wr_addr0", wr_addr, 513);
    chk("t6b_done0",    done,    0);
    pix_data = 24'h040506;
    tick();
    pix_valid = 1'b0;
    chk("t6b_wr_addr1", wr_addr, 769);
    chk("t6b_wr_data1", wr_data, 32'h040506);
    chk("t6b_done1",    done,    1);
    tick();
    chk("t6b_cmd_ready", cmd_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
